// File: rtl/lstm_fwd_sched_pkg.sv
// lstm_fwd_sched_pkg: shared state encoding for the LSTM forward scheduler.
// The states stay plain 3-bit constants so they match older code that
// compares against raw values.
package lstm_fwd_sched_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_CLR    = 3'd1;
  localparam state_t S_MAC    = 3'd2;
  localparam state_t S_GAP    = 3'd3;
  localparam state_t S_WB     = 3'd4;
  localparam state_t S_NEXT_T = 3'd5;
  localparam state_t S_DONE   = 3'd6;

endpackage

// File: rtl/lstm_term_cnt.sv
// lstm_term_cnt: enable counter that wraps to zero after a parameterised
// terminal value. It has a synchronous clear that overrides the enable, and
// o_tc flags that the count currently sits at the terminal value.
module lstm_term_cnt
  import lstm_fwd_sched_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int TERM  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count,
  output logic             o_tc
);

  localparam logic [WIDTH-1:0] L_TERM = WIDTH'(TERM);
  localparam logic [WIDTH-1:0] L_ONE  = WIDTH'(1);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_next;

  assign o_count = r_count;
  assign o_tc    = (r_count == L_TERM);

  // Clear wins over enable; an enabled count at the terminal value wraps to zero.
  always_comb begin
    w_next = r_count;
    if (i_clr) begin
      w_next = '0;
    end else if (i_en) begin
      w_next = o_tc ? '0 : (r_count + L_ONE);
    end
  end

  // Count register, cleared asynchronously by the active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else begin
      r_count <= w_next;
    end
  end

endmodule

// File: rtl/lstm_fwd_sched.sv
// lstm_fwd_sched: forward-propagation scheduler for one LSTM layer.
// For every timestep it runs a MAC pass per cell, lets the MAC pipeline drain,
// then writes back h/c for all cells. Slot t=0 of the h/c store holds the zero
// state, so timestep t writes to slot t+1.
module lstm_fwd_sched
  import lstm_fwd_sched_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int TIMESTEP   = 7,
  parameter int NUM_CELL   = 53,
  parameter int NUM_INPUT  = 53,
  parameter int DELAY      = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic                  i_stall,
  output logic                  o_gen_clr,
  output logic                  o_gen_en,
  output logic                  o_acc_latch,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [ADDR_WIDTH-1:0] o_t,
  output logic [ADDR_WIDTH-1:0] o_cell,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam logic [ADDR_WIDTH-1:0] L_ONE        = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] L_NUM_CELL   = ADDR_WIDTH'(NUM_CELL);
  localparam logic [ADDR_WIDTH-1:0] L_GAP_PENULT = ADDR_WIDTH'(DELAY - 2);

  state_t r_state;
  state_t w_nextState;

  logic                  w_clrCnt;
  logic                  w_kEn;
  logic                  w_gapEn;
  logic                  w_cellEn;
  logic                  w_tEn;
  logic                  w_kTc;
  logic                  w_gapTc;
  logic                  w_cellTc;
  logic                  w_tTc;
  logic [ADDR_WIDTH-1:0] w_unusedKCount;
  logic [ADDR_WIDTH-1:0] w_gapCount;
  logic [ADDR_WIDTH-1:0] w_cellCount;
  logic [ADDR_WIDTH-1:0] w_tCount;

  logic [ADDR_WIDTH-1:0] w_wrBase;
  logic [ADDR_WIDTH-1:0] w_wrCell;
  logic [ADDR_WIDTH-1:0] w_wrStep;
  logic [ADDR_WIDTH-1:0] w_wrAddrNext;
  logic                  w_accNext;

  logic                  r_genClr;
  logic                  r_macPhase;
  logic                  r_accLatch;
  logic                  r_wbPhase;
  logic [ADDR_WIDTH-1:0] r_wrAddr;
  logic                  r_busy;
  logic                  r_done;

  // Counters are held at zero while idle, on the run-start clear, and on abort.
  assign w_clrCnt = (r_state == S_IDLE) || (r_state == S_CLR) || i_abort;
  assign w_kEn    = (r_state == S_MAC) && !i_stall;
  assign w_gapEn  = (r_state == S_GAP);
  assign w_cellEn = ((r_state == S_GAP) && w_gapTc) || ((r_state == S_WB) && !i_stall);
  assign w_tEn    = (r_state == S_NEXT_T);

  // k walks the concatenated input + recurrent vector for one cell; only its
  // terminal flag matters here, the address generators keep their own copy.
  lstm_term_cnt #(.WIDTH(ADDR_WIDTH), .TERM(NUM_INPUT + NUM_CELL - 1)) u_kCnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_clrCnt),
    .i_en    (w_kEn),
    .o_count (w_unusedKCount),
    .o_tc    (w_kTc)
  );

  lstm_term_cnt #(.WIDTH(ADDR_WIDTH), .TERM(DELAY - 1)) u_gapCnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_clrCnt),
    .i_en    (w_gapEn),
    .o_count (w_gapCount),
    .o_tc    (w_gapTc)
  );

  lstm_term_cnt #(.WIDTH(ADDR_WIDTH), .TERM(NUM_CELL - 1)) u_cellCnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_clrCnt),
    .i_en    (w_cellEn),
    .o_count (w_cellCount),
    .o_tc    (w_cellTc)
  );

  lstm_term_cnt #(.WIDTH(ADDR_WIDTH), .TERM(TIMESTEP - 1)) u_tCnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_clrCnt),
    .i_en    (w_tEn),
    .o_count (w_tCount),
    .o_tc    (w_tTc)
  );

  // Next-state decode; abort from any active state overrides every other transition.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:   if (i_start) w_nextState = S_CLR;
      S_CLR:    w_nextState = S_MAC;
      S_MAC:    if (!i_stall && w_kTc) w_nextState = S_GAP;
      S_GAP:    if (w_gapTc) w_nextState = w_cellTc ? S_WB : S_MAC;
      S_WB:     if (!i_stall && w_cellTc) w_nextState = S_NEXT_T;
      S_NEXT_T: w_nextState = w_tTc ? S_DONE : S_MAC;
      S_DONE:   w_nextState = S_IDLE;
      default:  w_nextState = S_IDLE;
    endcase
    if (i_abort && (r_state != S_IDLE)) begin
      w_nextState = S_IDLE;
    end
  end

  // Write address for the cycle after this one: slot (t+1), cell offset.
  // WB is only entered from GAP with the cell count wrapping to zero, and
  // inside WB the address steps with the cell whenever memory accepts a write.
  assign w_wrBase     = (w_tCount + L_ONE) * L_NUM_CELL;
  assign w_wrCell     = (r_state == S_WB) ? w_cellCount : '0;
  assign w_wrStep     = ((r_state == S_WB) && !i_stall) ? L_ONE : '0;
  assign w_wrAddrNext = w_wrBase + w_wrCell + w_wrStep;

  // The latch pulse lands on the last drain cycle: either a one-cycle drain
  // entered from MAC, or the cycle after the gap counter reaches DELAY-2.
  assign w_accNext = (w_nextState == S_GAP) &&
                     ((r_state != S_GAP) ? (DELAY == 1) : (w_gapCount == L_GAP_PENULT));

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Registered outputs decoded from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_genClr   <= 1'b0;
      r_macPhase <= 1'b0;
      r_accLatch <= 1'b0;
      r_wbPhase  <= 1'b0;
      r_wrAddr   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_genClr   <= (w_nextState == S_CLR);
      r_macPhase <= (w_nextState == S_MAC);
      r_accLatch <= w_accNext;
      r_wbPhase  <= (w_nextState == S_WB);
      r_wrAddr   <= (w_nextState == S_WB) ? w_wrAddrNext : '0;
      r_busy     <= (w_nextState != S_IDLE);
      r_done     <= (w_nextState == S_DONE);
    end
  end

  // Enable and write strobe drop in the same cycle memory pushes back, so a
  // stalled cycle never issues a MAC step or a write.
  assign o_gen_clr   = r_genClr;
  assign o_gen_en    = r_macPhase & ~i_stall;
  assign o_acc_latch = r_accLatch;
  assign o_wr_en     = r_wbPhase & ~i_stall;
  assign o_wr_addr   = r_wrAddr;
  assign o_t         = w_tCount;
  assign o_cell      = w_cellCount;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_lstm_fwd_sched.sv
// tb_lstm_fwd_sched: directed checks of the LSTM forward scheduler, using a
// small configuration for control scenarios and the default one for a full run.
module tb_lstm_fwd_sched;

  logic clk = 1'b0;

  logic smallRst, smallStart, smallAbort, smallStall;
  logic sGenClr, sGenEn, sAccLatch, sWrEn, sBusy, sDone;
  logic [11:0] sWrAddr, sT, sCell;

  logic bigRst, bigStart, bigAbort, bigStall;
  logic bGenClr, bGenEn, bAccLatch, bWrEn, bBusy, bDone;
  logic [11:0] bWrAddr, bT, bCell;

  int assertCount = 0;
  int failCount   = 0;

  int busyCycles, doneCnt, accCnt, clrCnt, stallWrViol, stallGenViol;
  int wrAddrs[$];
  bit finished;

  always #5 clk = ~clk;

  lstm_fwd_sched #(
    .ADDR_WIDTH (12),
    .TIMESTEP   (2),
    .NUM_CELL   (2),
    .NUM_INPUT  (3),
    .DELAY      (1)
  ) dutSmall (
    .clk         (clk),
    .rst         (smallRst),
    .i_start     (smallStart),
    .i_abort     (smallAbort),
    .i_stall     (smallStall),
    .o_gen_clr   (sGenClr),
    .o_gen_en    (sGenEn),
    .o_acc_latch (sAccLatch),
    .o_wr_en     (sWrEn),
    .o_wr_addr   (sWrAddr),
    .o_t         (sT),
    .o_cell      (sCell),
    .o_busy      (sBusy),
    .o_done      (sDone)
  );

  lstm_fwd_sched dutBig (
    .clk         (clk),
    .rst         (bigRst),
    .i_start     (bigStart),
    .i_abort     (bigAbort),
    .i_stall     (bigStall),
    .o_gen_clr   (bGenClr),
    .o_gen_en    (bGenEn),
    .o_acc_latch (bAccLatch),
    .o_wr_en     (bWrEn),
    .o_wr_addr   (bWrAddr),
    .o_t         (bT),
    .o_cell      (bCell),
    .o_busy      (bBusy),
    .o_done      (bDone)
  );

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // One run of the small DUT: start pulse, optional stall windows, abort or
  // async reset at a given busy cycle, optional start held high throughout.
  task automatic applyStimulus(input bit useStall, input int abortAt, input int resetAt,
                               input bit holdStart);
    busyCycles = 0; doneCnt = 0; accCnt = 0; clrCnt = 0;
    stallWrViol = 0; stallGenViol = 0; finished = 0;
    wrAddrs.delete();
    @(posedge clk); #1;
    smallStart = 1'b1; smallStall = 1'b0; smallAbort = 1'b0;
    @(negedge clk);
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      smallStart = holdStart;
      smallStall = useStall && (c == 3 || c == 4 || c == 5 || c == 18 || c == 19);
      smallAbort = (c == abortAt);
      @(negedge clk);
      if (sBusy) busyCycles++;
      if (sDone) doneCnt++;
      if (sAccLatch) accCnt++;
      if (sGenClr) clrCnt++;
      if (sWrEn) wrAddrs.push_back(int'(sWrAddr));
      if (smallStall && sWrEn) stallWrViol++;
      if (smallStall && sGenEn) stallGenViol++;
      if (c == abortAt) begin
        checkOutput("abortGapT", int'(sT), 1);
        checkOutput("abortGapLatch", int'(sAccLatch), 1);
      end
      if (c == resetAt) begin
        checkOutput("preResetWrEn", int'(sWrEn), 1);
        checkOutput("preResetAddr", int'(sWrAddr), 4);
        checkOutput("preResetT", int'(sT), 1);
        #2 smallRst = 1'b0;
        #1;
        checkOutput("asyncResetFlags",
                    int'({sGenClr, sGenEn, sAccLatch, sWrEn, sBusy, sDone}), 0);
        checkOutput("asyncResetAddr", int'(sWrAddr), 0);
        checkOutput("asyncResetTCell", int'({sT, sCell}), 0);
        finished = 1;
        break;
      end
      if (!sBusy) begin
        finished = 1;
        break;
      end
    end
    if (!finished) checkOutput("runTimeout", 0, 1);
  endtask

  initial begin
    int bigBusy, bigDone, bigAcc, bigClr, bigWr, bigOrderErr, bigFirst, bigLast;
    bit bigFinished;

    smallRst = 1'b0; smallStart = 1'b0; smallAbort = 1'b0; smallStall = 1'b0;
    bigRst = 1'b0; bigStart = 1'b0; bigAbort = 1'b0; bigStall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    smallRst = 1'b1;
    bigRst = 1'b1;
    @(negedge clk);
    checkOutput("resetFlagsSmall", int'({sGenClr, sGenEn, sAccLatch, sWrEn, sBusy, sDone}), 0);
    checkOutput("resetCountsSmall", int'({sWrAddr, sT, sCell}), 0);
    checkOutput("resetFlagsBig", int'({bGenClr, bGenEn, bAccLatch, bWrEn, bBusy, bDone}), 0);

    $display("[TB] small config, no stall");
    applyStimulus(1'b0, 0, 0, 1'b0);
    checkOutput("plainBusy", busyCycles, 32);
    checkOutput("plainDone", doneCnt, 1);
    checkOutput("plainAcc", accCnt, 4);
    checkOutput("plainClr", clrCnt, 1);
    checkOutput("plainWrCount", wrAddrs.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < wrAddrs.size()) checkOutput($sformatf("plainAddr%0d", i), wrAddrs[i], 2 + i);

    $display("[TB] small config with stall windows");
    applyStimulus(1'b1, 0, 0, 1'b0);
    checkOutput("stallBusy", busyCycles, 37);
    checkOutput("stallDone", doneCnt, 1);
    checkOutput("stallWrWhileStalled", stallWrViol, 0);
    checkOutput("stallGenWhileStalled", stallGenViol, 0);
    checkOutput("stallWrCount", wrAddrs.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < wrAddrs.size()) checkOutput($sformatf("stallAddr%0d", i), wrAddrs[i], 2 + i);

    $display("[TB] abort during GAP of timestep 1");
    applyStimulus(1'b0, 22, 0, 1'b0);
    checkOutput("abortBusyCycles", busyCycles, 22);
    checkOutput("abortNoDone", doneCnt, 0);
    checkOutput("abortIdleBusy", int'(sBusy), 0);
    checkOutput("abortClearedTCell", int'({sT, sCell}), 0);
    checkOutput("abortWrCount", wrAddrs.size(), 2);
    applyStimulus(1'b0, 0, 0, 1'b0);
    checkOutput("rerunBusy", busyCycles, 32);
    checkOutput("rerunDone", doneCnt, 1);
    if (wrAddrs.size() > 0) checkOutput("rerunFirstAddr", wrAddrs[0], 2);
    else checkOutput("rerunFirstAddr", -1, 2);

    $display("[TB] async reset during WB");
    applyStimulus(1'b0, 0, 29, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    smallRst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("idleAfterReset%0d", i), int'(sBusy), 0);
    end
    applyStimulus(1'b0, 0, 0, 1'b0);
    checkOutput("postResetBusy", busyCycles, 32);

    $display("[TB] start held high");
    applyStimulus(1'b0, 0, 0, 1'b1);
    checkOutput("holdBusy", busyCycles, 32);
    checkOutput("holdDone", doneCnt, 1);
    checkOutput("holdClr", clrCnt, 1);
    @(posedge clk); #1;
    smallStart = 1'b0;
    smallAbort = 1'b1;
    @(negedge clk);
    checkOutput("holdRestartClr", int'(sGenClr), 1);
    checkOutput("holdRestartBusy", int'(sBusy), 1);
    @(posedge clk); #1;
    smallAbort = 1'b0;
    @(negedge clk);
    checkOutput("holdAbortIdle", int'(sBusy), 0);

    $display("[TB] default config full run");
    bigBusy = 0; bigDone = 0; bigAcc = 0; bigClr = 0; bigWr = 0;
    bigOrderErr = 0; bigFirst = -1; bigLast = -1; bigFinished = 0;
    @(posedge clk); #1;
    bigStart = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 45000; c++) begin
      @(posedge clk); #1;
      bigStart = 1'b0;
      @(negedge clk);
      if (bBusy) bigBusy++;
      if (bDone) bigDone++;
      if (bAccLatch) bigAcc++;
      if (bGenClr) bigClr++;
      if (bWrEn) begin
        if (int'(bWrAddr) != 53 + bigWr) bigOrderErr++;
        if (bigWr == 0) bigFirst = int'(bWrAddr);
        bigLast = int'(bWrAddr);
        bigWr++;
      end
      if (!bBusy) begin
        bigFinished = 1;
        break;
      end
    end
    if (!bigFinished) checkOutput("bigTimeout", 0, 1);
    checkOutput("bigBusy", bigBusy, 41561);
    checkOutput("bigDone", bigDone, 1);
    checkOutput("bigWrCount", bigWr, 371);
    checkOutput("bigAddrOrderErrors", bigOrderErr, 0);
    checkOutput("bigFirstAddr", bigFirst, 53);
    checkOutput("bigLastAddr", bigLast, 423);
    checkOutput("bigAcc", bigAcc, 371);
    checkOutput("bigClr", bigClr, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
